// File: rtl/seq_shift_unit.sv
// seq_shift_unit: iterative SLL/SRL/SRA execution unit, STEP bit positions per clock, valid/ready on both sides
module seq_shift_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand,
  input  logic [XLEN-1:0] shamt_in,
  input  logic [1:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [1:0] OP_SLL = 2'b00, OP_SRL = 2'b01, OP_PASS = 2'b11;
  // cnt never exceeds 31, so a STEP of 32 behaves exactly like 31
  localparam logic [4:0] SMAX = (STEP >= 32) ? 5'd31 : 5'(STEP);
  state_t state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d, res_q, res_d, sra;
  logic [4:0] cnt_q, cnt_d, n;
  logic [1:0] op_q, op_d;
  logic accept, unused_hi;
  assign unused_hi = ^shamt_in[XLEN-1:5];
  assign in_ready = !flush && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign result = res_q;
  assign n = (cnt_q < SMAX) ? cnt_q : SMAX;
  assign sra = $signed(acc_q) >>> n;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    op_d = op_q;
    if (flush) state_d = IDLE;
    else if (accept) begin
      acc_d = operand;
      cnt_d = shamt_in[4:0];
      op_d = op;
      state_d = (shamt_in[4:0] == 5'd0 || op == OP_PASS) ? DONE : SHIFT;
    end else if (state_q == SHIFT) begin
      acc_d = (op_q == OP_SLL) ? acc_q << n : (op_q == OP_SRL) ? acc_q >> n : sra;
      cnt_d = cnt_q - n;
      state_d = (cnt_d == 5'd0) ? DONE : SHIFT;
    end else if (state_q == DONE && out_ready) state_d = IDLE;
    // result only moves when a value lands in DONE, so it holds across IDLE/SHIFT
    res_d = (state_d == DONE) ? acc_d : res_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      op_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      res_q <= res_d;
    end
  end
endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Multi-cycle shift execution unit that consumes the zero-extended 32-bit shift amount produced by the instruction shamt extractor, together with an operand and a shift opcode.
- Performs SLL, SRL or SRA iteratively, STEP bit positions per clock.
- Uses a valid/ready handshake on both sides, so it slots in as an EX-stage functional unit that stalls the pipeline while busy.

Parameters:
- XLEN, 32, datapath width; fixed at 32 for this core.
- STEP, 1, bit positions shifted per cycle; legal values 1, 2, 4, 8, 16, 32.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; discards any operation in flight.
- in_valid  input  1  operand, shamt_in and op are valid.
- in_ready  output  1  unit can accept a new operation.
- operand  input  32  value to shift.
- shamt_in  input  32  zero-extended shift amount; only [4:0] is used, [31:5] is ignored.
- op  input  2  00=SLL, 01=SRL, 10=SRA, 11=PASS (result = operand, no shift).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts result.
- result  output  32  shifted value.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; internal registers cleared.
  - result=0, out_valid=0, busy=0, in_ready=1.
- States are IDLE, SHIFT and DONE.
- Accept: an operation is accepted on a rising edge with in_valid & in_ready.
  - On accept, latch acc=operand, cnt=shamt_in[4:0], and op.
  - cnt==0 or op==PASS: go to DONE.
  - Otherwise: go to SHIFT.
- SHIFT, each edge:
  - n = min(STEP, cnt).
  - acc shifts by n: left zero-fill for SLL, right zero-fill for SRL, right sign-fill (replicating acc[31]) for SRA.
  - cnt -= n; if the new cnt==0, go to DONE.
- DONE:
  - out_valid=1; result=acc, held stable while out_ready is low.
  - On the out_valid & out_ready edge: go to IDLE, or accept a new operation on the same edge (see in_ready).
- in_ready = (state==IDLE) | (state==DONE & out_ready), both qualified by !flush.
  - Back-to-back operations incur zero bubble on the input side.
- Latency: cycles from the accept edge to out_valid high = 1 + ceil(k/STEP), where k=shamt_in[4:0].
  - k=0 or PASS gives 1 cycle; k=31 with STEP=1 gives 32 cycles.
- result is updated only on DONE entry; outside DONE it holds the last completed value (0 after reset). out_valid is low outside DONE.
- flush high on an edge:
  - state goes to IDLE; out_valid=0 next cycle.
  - An input presented the same cycle is not accepted (in_ready is low during flush).
  - A completed-but-unconsumed result is dropped.
  - flush has priority over all other transitions.
- Simultaneous out handshake and new accept in DONE: the new operation is latched and the old result is consumed. out_valid drops for at least one cycle unless the new k=0 or op=PASS, in which case it stays high with the new result.
- shamt_in[31:5] nonzero: silently ignored, matching RV32 semantics.
- Reset mid-SHIFT: immediate abort to the reset state; no partial result is ever presented.

Test Plan:
- SRA: operand=0x80000000, shamt_in=4, op=10, STEP=1, out_ready=1 -> result=0xF8000000; out_valid rises exactly 5 cycles after the accept edge; busy high throughout.
- SLL max: operand=0x00000001, shamt_in=31, op=00 -> result=0x80000000 after 32 cycles. Repeat with STEP=4: same result after 9 cycles.
- Upper bits ignored: operand=0xF0000000, shamt_in=0x00000024, op=01 -> result=0x0F000000 (shift by 4); a zero shift gives result=operand in 1 cycle.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles in DONE -> result and out_valid stable, in_ready=0.
  - Raise out_ready with in_valid=1 (operand=0x12345678, shamt_in=0, op=11) -> second result 0x12345678 on the next cycle; no lost or duplicated output.
- Flush and reset:
  - Assert flush on the 2nd SHIFT cycle of SRL 0xFFFFFFFF by 10 -> state IDLE and out_valid never rises.
  - Pull rst_n low mid-shift, asynchronously between edges -> outputs return immediately to result=0, out_valid=0, in_ready=1.
